// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with load, enable and wrap-or-saturate bounds.
// Latency: count/carry registered (1 cycle); at_max/at_min decode count combinationally.
// Backpressure: none; en gates stepping, load overrides en, rst overrides all.
module counter_updown_n #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             at_max,
  output logic             at_min
);

  // Top of the count range; MODULUS = 2**WIDTH gives all-ones here.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;

  // Next-state: load (clamped into range) beats stepping; bounds use explicit
  // compares so a non-power-of-two modulus never lets count leave 0..MODULUS-1.
  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    if (load) begin
      count_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (up) begin
        if (count == MAX_CNT) begin
          carry_nxt = 1'b1;
          count_nxt = SAT ? count : '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (count == '0) begin
          carry_nxt = 1'b1;
          count_nxt = SAT ? count : MAX_CNT;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_CNT;
      carry <= 1'b0;
    end else begin
      count <= count_nxt;
      carry <= carry_nxt;
    end
  end

  assign at_max = (count == MAX_CNT);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_counter_updown_n.sv
// Directed table-driven bench for counter_updown_n over three parameter sets:
// d0 = default (mod 16 wrap), d1 = mod 10 wrap, d2 = mod 10 saturate with RST_VAL 3.
module tb_counter_updown_n;

  logic       clk = 1'b0;
  logic       rst   [3];
  logic       en    [3];
  logic       up    [3];
  logic       load  [3];
  logic [3:0] lval  [3];
  logic [3:0] count [3];
  logic       carry [3];
  logic       amax  [3];
  logic       amin  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_updown_n u_d0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .load(load[0]), .load_val(lval[0]),
    .count(count[0]), .carry(carry[0]), .at_max(amax[0]), .at_min(amin[0]));

  counter_updown_n #(.WIDTH(4), .MODULUS(10)) u_d1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .load(load[1]), .load_val(lval[1]),
    .count(count[1]), .carry(carry[1]), .at_max(amax[1]), .at_min(amin[1]));

  counter_updown_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RST_VAL(3)) u_d2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .load(load[2]), .load_val(lval[2]),
    .count(count[2]), .carry(carry[2]), .at_max(amax[2]), .at_min(amin[2]));

  typedef struct {
    int         which;
    bit         rst, en, up, load;
    logic [3:0] lv;
    logic [3:0] ecount;
    bit         ecarry, emax, emin;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int w, bit r, bit e, bit u, bit l, logic [3:0] lv,
                              logic [3:0] ec, bit ecy, bit emx, bit emn);
    vec_t v;
    v.which = w; v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
    v.ecount = ec; v.ecarry = ecy; v.emax = emx; v.emin = emn;
    return v;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b0; load[k] = 1'b0; lval[k] = 4'd0;
    end
  endtask

  task automatic check(string name, int w, logic [3:0] ec, bit ecy, bit emx, bit emn);
    total++;
    if (count[w] !== ec || carry[w] !== ecy || amax[w] !== emx || amin[w] !== emn) begin
      bad++;
      $display("FAIL %s d%0d: got count=%0d carry=%b max=%b min=%b, want count=%0d carry=%b max=%b min=%b",
               name, w, count[w], carry[w], amax[w], amin[w], ec, ecy, emx, emn);
    end
  endtask

  initial begin
    int ncarry;
    idle_all();

    // d0: two reset cycles, then count down: 0 -> 15 (carry) -> ... -> 0 -> 15 (carry).
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 4'd0, 0, 0, 1));
    for (int i = 1; i <= 16; i++)
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 4'(16 - i), i == 1, i == 1, i == 16));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 4'd15, 1, 1, 0));

    // d1: mod 10 count up from reset: 1..9, 0 (carry), 1.
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1));
    for (int i = 1; i <= 9; i++)
      vq.push_back(mk(1, 0, 1, 1, 0, 0, 4'(i), 0, i == 9, 0));
    vq.push_back(mk(1, 0, 1, 1, 0, 0, 4'd0, 1, 0, 1));
    vq.push_back(mk(1, 0, 1, 1, 0, 0, 4'd1, 0, 0, 0));
    // d1: load 13 clamps to 9; load 4 with en/up wins over stepping.
    vq.push_back(mk(1, 0, 0, 0, 1, 4'd13, 4'd9, 0, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 1, 4'd4,  4'd4, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 0, 0,     4'd5, 0, 0, 0));
    // d1: reset at 5 with en and load asserted -> 0, then resumes from 0.
    vq.push_back(mk(1, 1, 1, 1, 1, 4'd7,  4'd0, 0, 0, 1));
    vq.push_back(mk(1, 0, 1, 1, 0, 0,     4'd1, 0, 0, 0));
    // d1: en=0 holds.
    vq.push_back(mk(1, 0, 0, 1, 0, 0,     4'd1, 0, 0, 0));

    // d2: reset to RST_VAL 3, load 7, up x5 saturates at 9 with repeating carry, then down.
    vq.push_back(mk(2, 1, 0, 0, 0, 0,    4'd3, 0, 0, 0));
    vq.push_back(mk(2, 0, 0, 0, 1, 4'd7, 4'd7, 0, 0, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0,    4'd8, 0, 0, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0,    4'd9, 0, 1, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0,    4'd9, 1, 1, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0,    4'd9, 1, 1, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0,    4'd9, 1, 1, 0));
    vq.push_back(mk(2, 0, 1, 0, 0, 0,    4'd8, 0, 0, 0));
    // d2: saturate at the bottom: load 0, down twice holds 0 with carry, en=0 drops carry.
    vq.push_back(mk(2, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 1));
    vq.push_back(mk(2, 0, 1, 0, 0, 0,    4'd0, 1, 0, 1));
    vq.push_back(mk(2, 0, 1, 0, 0, 0,    4'd0, 1, 0, 1));
    vq.push_back(mk(2, 0, 0, 0, 0, 0,    4'd0, 0, 0, 1));

    // d0: at 15, up -> 0 carry; down -> 15 carry; en=0 holds, carry clears.
    vq.push_back(mk(0, 0, 0, 0, 1, 4'd15, 4'd15, 0, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,     4'd0,  1, 0, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,     4'd15, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,     4'd15, 0, 1, 0));

    foreach (vq[i]) begin
      idle_all();
      rst[vq[i].which]  = vq[i].rst;
      en[vq[i].which]   = vq[i].en;
      up[vq[i].which]   = vq[i].up;
      load[vq[i].which] = vq[i].load;
      lval[vq[i].which] = vq[i].lv;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].which, vq[i].ecount, vq[i].ecarry, vq[i].emax, vq[i].emin);
    end

    // Carry period: d1 (mod 10) from 0 counting up for 30 edges gives exactly 3 carries;
    // d0 counting up from 15 for 32 edges gives exactly 2 carries and ends at 15.
    idle_all();
    rst[1] = 1'b1;
    load[0] = 1'b1; lval[0] = 4'd15;
    @(posedge clk); #1;
    idle_all();
    en[0] = 1'b1; up[0] = 1'b1;
    en[1] = 1'b1; up[1] = 1'b1;
    ncarry = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (carry[1]) ncarry++;
    end
    total++;
    if (ncarry != 3) begin
      bad++;
      $display("FAIL carry_period_d1: got %0d carries, want 3", ncarry);
    end
    check("d1_after_period", 1, 4'd0, 1, 0, 1);
    en[1] = 1'b0;
    ncarry = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (carry[0]) ncarry++;
    end
    total++;
    // Edges 1..32 from 15: carries on edge 1 and edge 17 (edge 1 already counted above via d0 run).
    // Recount d0 separately over a clean 32-edge window below.
    if (count[0] !== 4'd15) begin
      bad++;
      $display("FAIL d0_after_32: got count=%0d, want 15", count[0]);
    end
    ncarry = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (carry[0]) ncarry++;
    end
    total++;
    if (ncarry != 2) begin
      bad++;
      $display("FAIL carry_period_d0: got %0d carries, want 2", ncarry);
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
